// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects,
// ALU op classes, controller states and the decoded control word.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_t;

  // States that drive the memory and may stall on mem_ready.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM: Moore control decode with mem_ready wait
// states and a timeout that aborts stalled memory accesses.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  state_t        state, state_nx;
  logic [TW-1:0] wait_cnt;
  logic          in_mem, timeout;
  ctrl_t         c;

  assign in_mem  = is_mem_state(state);
  // A late mem_ready on the timeout cycle still completes the access.
  assign timeout = in_mem && !mem_ready && (wait_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst)                               wait_cnt <= '0;
    else if (in_mem && !mem_ready && !timeout) wait_cnt <= wait_cnt + TW'(1);
    else                                   wait_cnt <= '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:   if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXECUTE;
          OP_BEQ:       state_nx = S_BEQ;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
                 else if (timeout) state_nx = S_FETCH;
      S_MEMWR:   if (mem_ready || timeout) state_nx = S_FETCH;
      S_EXECUTE: state_nx = S_ALUWB;
      S_ADDIEX:  state_nx = S_ADDIWB;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b  = SRCB_IMM_SH;
        c.alu_op     = ALU_ADD;
        c.illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req    = 1'b1;
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALU_SUB;
        c.branch     = 1'b1;
        c.pc_src     = PC_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PC_JUMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    c.bus_err = timeout;
    if (rst) c = '0;
  end

  assign mem_req    = c.mem_req;
  assign mem_write  = c.mem_write;
  assign iord       = c.iord;
  assign ir_write   = c.ir_write;
  assign pc_en      = c.pc_write | (c.branch & zero);
  assign pc_src     = c.pc_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign reg_write  = c.reg_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign instr_done = c.instr_done;
  assign illegal_op = c.illegal_op;
  assign bus_err    = c.bus_err;

endmodule
